// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants, types and helpers for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int INST_BITS = 16;

  typedef enum logic [1:0] {
    DES_IDLE,
    DES_BUSY,
    DES_DISCARD
  } des_state_e;

  function automatic int wordChunks(input int nshift);
    return INST_BITS / nshift;
  endfunction

  function automatic int chunkCntBits(input int nshift);
    int wc;
    wc = INST_BITS / nshift;
    return (wc > 1) ? $clog2(wc) : 1;
  endfunction

  function automatic logic [INST_BITS-1:0] signExtend8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  function automatic logic [INST_BITS-1:0] rotRight(input logic [INST_BITS-1:0] w,
                                                    input int nshift);
    return (w >> nshift) | (w << (INST_BITS - nshift));
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decoder-side signals of the instruction fetch queue.
// The master modport is the queue itself; slave is the environment around it.
interface inst_fetch_queue_if #(parameter int NSHIFT = 2);
  import inst_fetch_queue_pkg::*;

  logic                 fetch_ready;
  logic                 fetch_data_valid;
  logic [NSHIFT-1:0]    fetch_data;
  logic                 inst_valid;
  logic [INST_BITS-1:0] inst;
  logic                 inst_done;
  logic                 load_imm16;
  logic                 imm16_loaded;
  logic [INST_BITS-1:0] imm_full;
  logic [NSHIFT-1:0]    imm_data_in;
  logic                 next_imm_data;

  modport master (
    output fetch_ready, inst_valid, inst, imm16_loaded, imm_full, imm_data_in,
    input  fetch_data_valid, fetch_data, inst_done, load_imm16, next_imm_data
  );

  modport slave (
    input  fetch_ready, inst_valid, inst, imm16_loaded, imm_full, imm_data_in,
    output fetch_data_valid, fetch_data, inst_done, load_imm16, next_imm_data
  );

endinterface

// File: rtl/inst_fetch_queue_chunk_deserializer.sv
// Collects NSHIFT-bit chunks (LSB first) into 16-bit words. A word whose
// first chunk arrives without room is swallowed chunk by chunk in DES_DISCARD.
module inst_fetch_queue_chunk_deserializer
  import inst_fetch_queue_pkg::*;
#(
  parameter int NSHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 chunkValid_i,
  input  logic [NSHIFT-1:0]    chunkData_i,
  input  logic                 acceptFirst_i,
  output logic                 busy_o,
  output logic                 wordDone_o,
  output logic [INST_BITS-1:0] wordData_o
);

  localparam int WORD_CHUNKS = wordChunks(NSHIFT);
  localparam int CNT_BITS    = chunkCntBits(NSHIFT);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORD_CHUNKS - 1);

  des_state_e           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [INST_BITS-1:0] sr_q, sr_d;
  logic [INST_BITS-1:0] shifted;
  logic                 lastChunk;

  assign lastChunk  = (cnt_q == LAST_CNT);
  assign shifted    = (sr_q >> NSHIFT) | (INST_BITS'(chunkData_i) << (INST_BITS - NSHIFT));
  assign wordData_o = shifted;
  assign busy_o     = (state_q == DES_BUSY);

  // Hold the chunk counter, shift register and word-tracking state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DES_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Advance on each chunk; flush drops the partial word and the chunk with it
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    wordDone_o = 1'b0;
    if (flush_i) begin
      state_d = DES_IDLE;
      cnt_d   = '0;
    end else if (chunkValid_i) begin
      sr_d  = shifted;
      cnt_d = lastChunk ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        DES_IDLE: begin
          if (lastChunk) begin
            wordDone_o = acceptFirst_i;
          end else begin
            state_d = acceptFirst_i ? DES_BUSY : DES_DISCARD;
          end
        end
        DES_BUSY: begin
          wordDone_o = lastChunk;
          if (lastChunk) state_d = DES_IDLE;
        end
        DES_DISCARD: begin
          if (lastChunk) state_d = DES_IDLE;
        end
        default: state_d = DES_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: deserialises fetched words into a small queue,
// presents the head to the decoder and manages the imm16 register.
// Optional macro INST_QUEUE_BYPASS_EN presents a word completing into an
// empty queue in the same cycle (zero latency).
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int NSHIFT = 2,
  parameter int DEPTH  = 2
) (
  input logic              clk,
  input logic              reset,
  input logic              flush_i,
  inst_fetch_queue_if.master fq
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_BITS-1:0] entry_q [DEPTH];
  logic [INST_BITS-1:0] entry_d [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 immLoaded_q, immLoaded_d;
  logic [INST_BITS-1:0] immSr_q, immSr_d;
  logic [INST_BITS-1:0] immFull_q, immFull_d;

  logic                 busy;
  logic                 wordDone;
  logic [INST_BITS-1:0] wordData;
  logic                 fetchReady;
  logic                 queueValid;
  logic                 bypassHit;
  logic                 instValid;
  logic                 pop;
  logic                 removeHead;
  logic                 immLoad;
  logic                 storeWord;
  logic                 newHead;
  logic [7:0]           headByte;

  inst_fetch_queue_chunk_deserializer #(.NSHIFT(NSHIFT)) u_deser (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .chunkValid_i  (fq.fetch_data_valid),
    .chunkData_i   (fq.fetch_data),
    .acceptFirst_i (fetchReady),
    .busy_o        (busy),
    .wordDone_o    (wordDone),
    .wordData_o    (wordData)
  );

  assign fetchReady = (int'(count_q) + int'(busy)) < DEPTH;
  assign queueValid = (count_q != '0);

`ifdef INST_QUEUE_BYPASS_EN
  assign bypassHit = (count_q == '0) && wordDone;
`else
  assign bypassHit = 1'b0;
`endif

  assign instValid  = queueValid || bypassHit;
  assign pop        = fq.inst_done && instValid;
  assign removeHead = pop && queueValid;
  assign storeWord  = wordDone && !(pop && bypassHit);
  assign immLoad    = fq.load_imm16 && !fq.inst_done && !immLoaded_q && (int'(count_q) >= 2);
  assign newHead    = pop || ((count_q == '0) && wordDone);

  assign fq.fetch_ready  = fetchReady;
  assign fq.inst_valid   = instValid;
  assign fq.inst         = queueValid ? entry_q[0] : (bypassHit ? wordData : '0);
  assign fq.imm16_loaded = immLoaded_q;
  assign fq.imm_full     = immFull_q;
  assign fq.imm_data_in  = immSr_q[NSHIFT-1:0];

  // Register queue entries, occupancy and immediate state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q     <= '0;
      immLoaded_q <= 1'b0;
      immSr_q     <= '0;
      immFull_q   <= '0;
    end else begin
      entry_q     <= entry_d;
      count_q     <= count_d;
      immLoaded_q <= immLoaded_d;
      immSr_q     <= immSr_d;
      immFull_q   <= immFull_d;
    end
  end

  // Remove (pop or imm16 take), then append the completed word, then update the immediate
  always_comb begin
    entry_d     = entry_q;
    count_d     = count_q;
    immLoaded_d = immLoaded_q;
    immSr_d     = immSr_q;
    immFull_d   = immFull_q;
    headByte    = '0;
    if (flush_i) begin
      count_d     = '0;
      immLoaded_d = 1'b0;
    end else begin
      if (removeHead || immLoad) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= (immLoad ? 1 : 0)) entry_d[i] = entry_q[i+1];
        end
        count_d = count_q - 1'b1;
      end
      if (storeWord) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (count_d == CNT_W'(i)) entry_d[i] = wordData;
        end
        count_d = count_d + 1'b1;
      end
      if (immLoad) begin
        immSr_d     = entry_q[1];
        immFull_d   = entry_q[1];
        immLoaded_d = 1'b1;
      end
      if (newHead) begin
        if (count_d != '0)  headByte = entry_d[0][7:0];
        else if (bypassHit) headByte = wordData[7:0];
        immSr_d     = signExtend8(headByte);
        immFull_d   = signExtend8(headByte);
        immLoaded_d = 1'b0;
      end else if (!immLoad && fq.next_imm_data) begin
        immSr_d = rotRight(immSr_q, NSHIFT);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue (NSHIFT=2, DEPTH=2).
module tb_inst_fetch_queue;

  localparam int NS    = 2;
  localparam int DEPTH = 2;
  localparam int WC    = 16 / NS;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   failures;

  inst_fetch_queue_if #(.NSHIFT(NS)) fq ();

  inst_fetch_queue #(.NSHIFT(NS), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .fq      (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, described in terms of words and chunks
  logic [15:0] mq[$];
  int          mPc;
  logic [15:0] mWord;
  bit          mDiscard;
  bit          mInFlight;
  logic [15:0] mImmSr;
  logic [15:0] mImmFull;
  bit          mLoaded;

  function automatic bit modelReady();
    return (mq.size() + int'(mInFlight)) < DEPTH;
  endfunction

  task automatic modelReset();
    mq.delete();
    mPc = 0; mWord = '0; mDiscard = 0; mInFlight = 0;
    mImmSr = '0; mImmFull = '0; mLoaded = 0;
  endtask

  task automatic modelEdge(input logic fdv, input logic [NS-1:0] fd, input logic done,
                           input logic ld, input logic nxt, input logic fl);
    bit completed, wasEmpty, popped, immLd, bypassPop;
    logic [15:0] word, head;
    completed = 0;
    word = '0;
    if (fl) begin
      mq.delete(); mPc = 0; mInFlight = 0; mDiscard = 0; mLoaded = 0;
      return;
    end
    if (fdv) begin
      if (mPc == 0) begin
        mDiscard = !modelReady();
        mInFlight = !mDiscard;
        mWord = '0;
      end
      mWord[mPc*NS +: NS] = fd;
      mPc++;
      if (mPc == WC) begin
        mPc = 0; completed = !mDiscard; word = mWord; mInFlight = 0; mDiscard = 0;
      end
    end
    wasEmpty = (mq.size() == 0);
`ifdef INST_QUEUE_BYPASS_EN
    bypassPop = completed && wasEmpty && done;
`else
    bypassPop = 0;
`endif
    popped = (done && !wasEmpty) || bypassPop;
    immLd  = !done && ld && !mLoaded && (mq.size() >= 2);
    if (done && !wasEmpty) void'(mq.pop_front());
    if (immLd) begin
      mImmSr = mq[1]; mImmFull = mq[1]; mLoaded = 1;
      mq.delete(1);
    end
    if (completed && !bypassPop) mq.push_back(word);
    if (popped || (wasEmpty && completed)) begin
      head = (mq.size() != 0) ? mq[0] : (bypassPop ? word : 16'h0000);
      mImmSr = {{8{head[7]}}, head[7:0]};
      mImmFull = mImmSr;
      mLoaded = 0;
    end else if (!immLd && nxt) begin
      mImmSr = (mImmSr >> NS) | (mImmSr << (16 - NS));
    end
  endtask

  task automatic idleInputs();
    fq.fetch_data_valid = 1'b0; fq.fetch_data = '0; fq.inst_done = 1'b0;
    fq.load_imm16 = 1'b0; fq.next_imm_data = 1'b0; flush = 1'b0;
  endtask

  task automatic cycle(input logic fdv, input logic [NS-1:0] fd, input logic done,
                       input logic ld, input logic nxt, input logic fl);
    fq.fetch_data_valid = fdv; fq.fetch_data = fd; fq.inst_done = done;
    fq.load_imm16 = ld; fq.next_imm_data = nxt; flush = fl;
    @(posedge clk);
    modelEdge(fdv, fd, done, ld, nxt, fl);
    #1;
    idleInputs();
  endtask

  task automatic sendChunks(input logic [15:0] w, input int n, input logic doneLast, input logic ldAll);
    logic [15:0] sh;
    for (int k = 0; k < n; k++) begin
      sh = w >> (k * NS);
      cycle(1'b1, sh[NS-1:0], doneLast && (k == WC - 1), ldAll, 1'b0, 1'b0);
    end
  endtask

  task automatic applyReset();
    idleInputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    applyReset();
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %0b want 1", fq.fetch_ready); end
    checks++; if (fq.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b want 0", fq.inst_valid); end
    checks++; if (fq.inst !== 16'h0000) begin failures++; $display("[TB] FAIL reset_inst: got %h want 0000", fq.inst); end
    checks++; if (fq.imm16_loaded !== 1'b0) begin failures++; $display("[TB] FAIL reset_loaded: got %0b want 0", fq.imm16_loaded); end
    checks++; if (fq.imm_full !== 16'h0000) begin failures++; $display("[TB] FAIL reset_imm_full: got %h want 0000", fq.imm_full); end
    checks++; if (fq.imm_data_in !== 2'd0) begin failures++; $display("[TB] FAIL reset_imm_data: got %0d want 0", fq.imm_data_in); end
  endtask

  task automatic test_single_word();
    applyReset();
    sendChunks(16'h1234, WC - 1, 1'b0, 1'b0);
    checks++; if (fq.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid: got %0b want 0", fq.inst_valid); end
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready_busy: got %0b want 1", fq.fetch_ready); end
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fq.inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid: got %0b want 1", fq.inst_valid); end
    checks++; if (fq.inst !== 16'h1234) begin failures++; $display("[TB] FAIL single_inst: got %h want 1234", fq.inst); end
    checks++; if (fq.imm_full !== 16'h0034) begin failures++; $display("[TB] FAIL single_imm_full: got %h want 0034", fq.imm_full); end
  endtask

  task automatic test_fill();
    applyReset();
    sendChunks(16'h2081, WC, 1'b0, 1'b0);
    sendChunks(16'hBEEF, WC, 1'b0, 1'b0);
    checks++; if (fq.fetch_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready: got %0b want 0", fq.fetch_ready); end
    checks++; if (fq.inst !== 16'h2081) begin failures++; $display("[TB] FAIL fill_head: got %h want 2081", fq.inst); end
    checks++; if (fq.imm_full !== 16'hFF81) begin failures++; $display("[TB] FAIL fill_imm_full: got %h want ff81", fq.imm_full); end
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fq.fetch_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready_hold: got %0b want 0", fq.fetch_ready); end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL pop_ready: got %0b want 1", fq.fetch_ready); end
    checks++; if (fq.inst !== 16'hBEEF) begin failures++; $display("[TB] FAIL pop_inst: got %h want beef", fq.inst); end
    checks++; if (fq.imm_full !== 16'hFFEF) begin failures++; $display("[TB] FAIL pop_imm_full: got %h want ffef", fq.imm_full); end
  endtask

  task automatic test_imm16();
    logic [15:0] v;
    logic [15:0] sh;
    applyReset();
    sendChunks(16'h2081, WC, 1'b0, 1'b0);
    sendChunks(16'hCAFE, WC, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (fq.imm16_loaded !== 1'b1) begin failures++; $display("[TB] FAIL imm_loaded: got %0b want 1", fq.imm16_loaded); end
    checks++; if (fq.imm_full !== 16'hCAFE) begin failures++; $display("[TB] FAIL imm_full: got %h want cafe", fq.imm_full); end
    checks++; if (fq.inst !== 16'h2081) begin failures++; $display("[TB] FAIL imm_head: got %h want 2081", fq.inst); end
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL imm_ready: got %0b want 1", fq.fetch_ready); end
    v = 16'hCAFE;
    for (int k = 0; k <= WC; k++) begin
      sh = v >> ((k % WC) * NS);
      checks++; if (fq.imm_data_in !== sh[NS-1:0]) begin failures++; $display("[TB] FAIL imm_stream_%0d: got %0d want %0d", k, fq.imm_data_in, sh[NS-1:0]); end
      cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++; if (fq.imm_full !== 16'hCAFE) begin failures++; $display("[TB] FAIL imm_full_stable: got %h want cafe", fq.imm_full); end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fq.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL imm_done_empty: got %0b want 0", fq.inst_valid); end
    checks++; if (fq.imm16_loaded !== 1'b0) begin failures++; $display("[TB] FAIL imm_done_cleared: got %0b want 0", fq.imm16_loaded); end
  endtask

  task automatic test_imm_wait();
    applyReset();
    sendChunks(16'h1111, WC, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (fq.imm16_loaded !== 1'b0) begin failures++; $display("[TB] FAIL wait_not_loaded: got %0b want 0", fq.imm16_loaded); end
    sendChunks(16'h0005, WC, 1'b0, 1'b1);
    checks++; if (fq.imm16_loaded !== 1'b0) begin failures++; $display("[TB] FAIL wait_same_cycle: got %0b want 0", fq.imm16_loaded); end
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (fq.imm16_loaded !== 1'b1) begin failures++; $display("[TB] FAIL wait_loaded: got %0b want 1", fq.imm16_loaded); end
    checks++; if (fq.imm_full !== 16'h0005) begin failures++; $display("[TB] FAIL wait_imm_full: got %h want 0005", fq.imm_full); end
  endtask

  task automatic test_flush();
    applyReset();
    sendChunks(16'h1357, WC, 1'b0, 1'b0);
    sendChunks(16'hABCD, 3, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (fq.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %0b want 0", fq.inst_valid); end
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready: got %0b want 1", fq.fetch_ready); end
    sendChunks(16'h4C2D, WC, 1'b0, 1'b0);
    checks++; if (fq.inst !== 16'h4C2D) begin failures++; $display("[TB] FAIL flush_new_inst: got %h want 4c2d", fq.inst); end
    checks++; if (fq.imm_full !== 16'h002D) begin failures++; $display("[TB] FAIL flush_new_imm: got %h want 002d", fq.imm_full); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    sendChunks(16'h1111, WC, 1'b0, 1'b0);
    sendChunks(16'h9876, WC, 1'b1, 1'b0);
    checks++; if (fq.inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid: got %0b want 1", fq.inst_valid); end
    checks++; if (fq.inst !== 16'h9876) begin failures++; $display("[TB] FAIL b2b_inst: got %h want 9876", fq.inst); end
    checks++; if (fq.fetch_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %0b want 1", fq.fetch_ready); end
    checks++; if (fq.imm_full !== 16'h0076) begin failures++; $display("[TB] FAIL b2b_imm: got %h want 0076", fq.imm_full); end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fq.inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain: got %0b want 0", fq.inst_valid); end
  endtask

`ifdef INST_QUEUE_BYPASS_EN
  task automatic test_bypass();
    logic [15:0] sh;
    applyReset();
    sendChunks(16'h5A3C, WC - 1, 1'b0, 1'b0);
    sh = 16'h5A3C >> ((WC - 1) * NS);
    fq.fetch_data_valid = 1'b1; fq.fetch_data = sh[NS-1:0];
    #1;
    checks++; if (fq.inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL bypass_valid: got %0b want 1", fq.inst_valid); end
    checks++; if (fq.inst !== 16'h5A3C) begin failures++; $display("[TB] FAIL bypass_inst: got %h want 5a3c", fq.inst); end
    @(posedge clk);
    modelEdge(1'b1, sh[NS-1:0], 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    idleInputs();
    checks++; if (fq.imm_full !== 16'h003C) begin failures++; $display("[TB] FAIL bypass_imm: got %h want 003c", fq.imm_full); end
  endtask
`endif

  task automatic test_random();
    logic fdv, done, ld, nxt, fl;
    logic [NS-1:0] fd;
    logic [15:0] expInst;
    int sel;
    applyReset();
    for (int n = 0; n < 600; n++) begin
      expInst = (mq.size() != 0) ? mq[0] : 16'h0000;
      checks++; if (fq.inst_valid !== (mq.size() != 0)) begin failures++; $display("[TB] FAIL rnd_valid @%0d: got %0b want %0b", n, fq.inst_valid, mq.size() != 0); end
      checks++; if (fq.inst !== expInst) begin failures++; $display("[TB] FAIL rnd_inst @%0d: got %h want %h", n, fq.inst, expInst); end
      checks++; if (fq.fetch_ready !== modelReady()) begin failures++; $display("[TB] FAIL rnd_ready @%0d: got %0b want %0b", n, fq.fetch_ready, modelReady()); end
      checks++; if (fq.imm16_loaded !== mLoaded) begin failures++; $display("[TB] FAIL rnd_loaded @%0d: got %0b want %0b", n, fq.imm16_loaded, mLoaded); end
      checks++; if (fq.imm_full !== mImmFull) begin failures++; $display("[TB] FAIL rnd_imm_full @%0d: got %h want %h", n, fq.imm_full, mImmFull); end
      checks++; if (fq.imm_data_in !== mImmSr[NS-1:0]) begin failures++; $display("[TB] FAIL rnd_imm_data @%0d: got %0d want %0d", n, fq.imm_data_in, mImmSr[NS-1:0]); end
      fdv = 1'b0;
      if (mPc != 0 || modelReady()) fdv = ($urandom_range(0, 3) != 0);
      fd   = NS'($urandom_range(0, (1 << NS) - 1));
      sel  = int'($urandom_range(0, 7));
      done = (sel <= 1);
      ld   = (sel == 2 || sel == 3);
      nxt  = ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 40) == 0);
      cycle(fdv, fd, done, ld, nxt, fl);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idleInputs();
    modelReset();
    test_reset();
    test_single_word();
    test_fill();
    test_imm16();
    test_imm_wait();
    test_flush();
    test_back_to_back();
`ifdef INST_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
